regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 99 +++++++++
 tb/tb_regfile_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Dual-bank (GPR/FPR) register file with a per-register busy scoreboard.
// Reads are combinational, and a same-cycle writeback is forwarded to the read ports.
module regfile_scoreboard #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      NREG     = 32,
  parameter int unsigned      NRD      = 2,
  parameter logic [XLEN-1:0]  INIT_G28 = 32'h000f4240,
  parameter logic [XLEN-1:0]  INIT_G29 = 32'h00000030,
  localparam int unsigned     AW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD*(AW+1)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic [1:0]          iss_rw,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic [1:0]          wb_rw,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                wb_clr,
  input  logic                flush,
  output logic [AW+1:0]       busy_cnt
);

  // Flat storage: index {bank, idx}, so GPR n sits at n and FPR n at NREG+n.
  logic [XLEN-1:0]   r_regs [2*NREG];
  logic [2*NREG-1:0] r_busy;
  logic [2*NREG-1:0] w_busy_d;

  logic          w_wb_sel;
  logic          w_wb_en;
  logic          w_clr_en;
  logic          w_iss_tgt;
  logic          w_set_en;
  logic [AW:0]   w_wb_addr;
  logic [AW:0]   w_iss_addr;

  assign w_wb_addr  = {wb_rw[1], wb_rd};
  assign w_wb_sel   = (wb_rw == 2'b01) || (wb_rw == 2'b10);
  assign w_wb_en    = w_wb_sel && (wb_rw[1] || (wb_rd != '0));
  assign w_clr_en   = wb_clr && w_wb_sel;

  assign w_iss_addr = {iss_rw[1], iss_rd};
  assign w_iss_tgt  = ((iss_rw == 2'b01) || (iss_rw == 2'b10)) && (iss_rw[1] || (iss_rd != '0));

  // A reservation whose target is being released this cycle may proceed.
  assign iss_ready  = !w_iss_tgt || !r_busy[w_iss_addr] ||
                      (w_clr_en && (w_wb_addr == w_iss_addr));
  assign w_set_en   = iss_valid && iss_ready && w_iss_tgt;

  always_comb begin
    w_busy_d = r_busy;
    if (w_clr_en) w_busy_d[w_wb_addr] = 1'b0;
    if (w_set_en) w_busy_d[w_iss_addr] = 1'b1;
    if (flush)    w_busy_d = '0;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2 * NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[28] <= INIT_G28;
      r_regs[29] <= INIT_G29;
    end else if (w_wb_en) begin
      r_regs[w_wb_addr] <= wb_data;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW:0] w_ra;
    logic        w_fwd;
    assign w_ra  = rd_addr[p*(AW+1) +: AW+1];
    assign w_fwd = w_wb_en && (w_wb_addr == w_ra);
    assign rd_data[p*XLEN +: XLEN] = (w_ra == '0) ? '0 :
                                     w_fwd        ? wb_data : r_regs[w_ra];
    assign rd_busy[p] = r_busy[w_ra] && !(w_clr_en && (w_wb_addr == w_ra));
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < 2 * NREG; i++) begin
      busy_cnt = busy_cnt + {{(AW+1){1'b0}}, r_busy[i]};
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: literal checks on key scenarios plus a
// bank-level model compared against every output on every falling edge.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [NRD*(AW+1)-1:0]   rd_addr;
  logic [NRD*XLEN-1:0]     rd_data;
  logic [NRD-1:0]          rd_busy;
  logic                    iss_valid;
  logic [1:0]              iss_rw;
  logic [AW-1:0]           iss_rd;
  logic                    iss_ready;
  logic [1:0]              wb_rw;
  logic [AW-1:0]           wb_rd;
  logic [XLEN-1:0]         wb_data;
  logic                    wb_clr;
  logic                    flush;
  logic [AW+1:0]           busy_cnt;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD)
  ) dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_rw(iss_rw), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wb_rw(wb_rw), .wb_rd(wb_rd), .wb_data(wb_data), .wb_clr(wb_clr), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bank-level model: separate GPR/FPR value arrays and busy flags.
  logic [XLEN-1:0] m_gpr [NREG];
  logic [XLEN-1:0] m_fpr [NREG];
  bit              m_gb  [NREG];
  bit              m_fb  [NREG];

  function automatic int bank_of(input logic [1:0] rw);
    return (rw == 2'b01) ? 0 : (rw == 2'b10) ? 1 : -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) begin
      m_gpr[i] = '0; m_fpr[i] = '0; m_gb[i] = 0; m_fb[i] = 0;
    end
    m_gpr[28] = 32'h000f4240;
    m_gpr[29] = 32'h00000030;
  endtask

  function automatic bit m_busy(input int b, input int i);
    return (b == 1) ? m_fb[i] : m_gb[i];
  endfunction

  // Model compare: inputs are stable at the falling edge, outputs have settled.
  initial begin
    int b, i, ib, cnt;
    logic [XLEN-1:0] e;
    bit eb, erdy;
    m_reset();
    forever begin
      @(negedge clk);
      if (!rstn) m_reset();
      for (int p = 0; p < NRD; p++) begin
        b = int'(rd_addr[p*6+5]);
        i = int'(rd_addr[p*6 +: 5]);
        if (b == 0 && i == 0)                          e = '0;
        else if (bank_of(wb_rw) == b && int'(wb_rd) == i) e = wb_data;
        else                                           e = (b == 1) ? m_fpr[i] : m_gpr[i];
        chk($sformatf("model rd_data%0d", p), 64'(rd_data[p*32 +: 32]), 64'(e));
        eb = m_busy(b, i) && !(wb_clr && bank_of(wb_rw) == b && int'(wb_rd) == i);
        chk($sformatf("model rd_busy%0d", p), 64'(rd_busy[p]), 64'(eb));
      end
      ib = bank_of(iss_rw);
      if (ib < 0 || (ib == 0 && iss_rd == 0))                     erdy = 1;
      else if (!m_busy(ib, int'(iss_rd)))                         erdy = 1;
      else if (wb_clr && bank_of(wb_rw) == ib && wb_rd == iss_rd) erdy = 1;
      else                                                        erdy = 0;
      chk("model iss_ready", 64'(iss_ready), 64'(erdy));
      cnt = 0;
      for (int k = 0; k < NREG; k++) cnt += int'(m_gb[k]) + int'(m_fb[k]);
      chk("model busy_cnt", 64'(busy_cnt), 64'(cnt));
      if (rstn) begin
        if (bank_of(wb_rw) == 0 && wb_rd != 0) m_gpr[wb_rd] = wb_data;
        if (bank_of(wb_rw) == 1)               m_fpr[wb_rd] = wb_data;
        if (wb_clr && bank_of(wb_rw) == 0) m_gb[wb_rd] = 0;
        if (wb_clr && bank_of(wb_rw) == 1) m_fb[wb_rd] = 0;
        if (iss_valid && erdy && ib == 0 && iss_rd != 0) m_gb[iss_rd] = 1;
        if (iss_valid && erdy && ib == 1)                m_fb[iss_rd] = 1;
        if (flush) for (int k = 0; k < NREG; k++) begin m_gb[k] = 0; m_fb[k] = 0; end
      end
    end
  end

  task automatic idle();
    iss_valid = 0; iss_rw = 2'b00; iss_rd = '0;
    wb_rw = 2'b00; wb_rd = '0; wb_data = '0; wb_clr = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input int p, input logic b, input logic [4:0] idx);
    rd_addr[p*6 +: 6] = {b, idx};
  endtask

  task automatic issue(input logic [1:0] rw, input logic [4:0] idx);
    iss_valid = 1; iss_rw = rw; iss_rd = idx;
  endtask

  task automatic wb(input logic [1:0] rw, input logic [4:0] idx, input logic [31:0] d,
                    input logic clr);
    wb_rw = rw; wb_rd = idx; wb_data = d; wb_clr = clr;
  endtask

  initial begin
    rstn = 1; rd_addr = '0; idle();
    #1 rstn = 0;
    setp(0, 0, 5'd28); setp(1, 0, 5'd29);
    #1;
    chk("reset G28", 64'(rd_data[31:0]), 64'h000f4240);
    chk("reset G29", 64'(rd_data[63:32]), 64'h00000030);
    chk("reset busy_cnt", 64'(busy_cnt), 64'd0);
    chk("reset iss_ready", 64'(iss_ready), 64'd1);
    setp(0, 1, 5'd5); #1;
    chk("reset F5", 64'(rd_data[31:0]), 64'h0);
    tick(); tick();
    rstn = 1;

    // Writeback bypass, then stored value; GPR 0 writes dropped.
    tick(); wb(2'b01, 5'd7, 32'hDEADBEEF, 0); setp(0, 0, 5'd7); #1;
    chk("bypass G7", 64'(rd_data[31:0]), 64'hDEADBEEF);
    tick(); idle(); #1;
    chk("stored G7", 64'(rd_data[31:0]), 64'hDEADBEEF);
    tick(); wb(2'b01, 5'd0, 32'h5, 0); setp(0, 0, 5'd0); #1;
    chk("G0 bypass", 64'(rd_data[31:0]), 64'h0);
    tick(); idle(); #1;
    chk("G0 stored", 64'(rd_data[31:0]), 64'h0);

    // WAW stall on F3, released by a same-cycle wb_clr.
    tick(); issue(2'b10, 5'd3); #1;
    chk("F3 first ready", 64'(iss_ready), 64'd1);
    tick(); idle(); setp(0, 1, 5'd3); #1;
    chk("F3 busy", 64'(rd_busy[0]), 64'd1);
    chk("busy_cnt one", 64'(busy_cnt), 64'd1);
    issue(2'b10, 5'd3); #1;
    chk("F3 WAW stall", 64'(iss_ready), 64'd0);
    tick(); wb(2'b10, 5'd3, 32'h77, 1); #1;
    chk("F3 clr ready", 64'(iss_ready), 64'd1);
    chk("F3 clr rd_busy", 64'(rd_busy[0]), 64'd0);
    tick(); idle(); #1;
    chk("F3 still busy", 64'(rd_busy[0]), 64'd1);
    chk("F3 data", 64'(rd_data[31:0]), 64'h77);
    tick(); wb(2'b10, 5'd3, 32'h78, 1);
    tick(); idle(); #1;
    chk("F3 released", 64'(busy_cnt), 64'd0);

    // Flush overrides a same-cycle issue.
    tick(); issue(2'b01, 5'd4);
    tick(); issue(2'b01, 5'd9);
    tick(); issue(2'b10, 5'd1);
    tick(); idle(); #1;
    chk("three reserved", 64'(busy_cnt), 64'd3);
    issue(2'b01, 5'd12); flush = 1; #1;
    chk("G12 ready", 64'(iss_ready), 64'd1);
    tick(); idle(); setp(0, 0, 5'd12); #1;
    chk("flush busy_cnt", 64'(busy_cnt), 64'd0);
    chk("G12 not busy", 64'(rd_busy[0]), 64'd0);

    // Asynchronous reset mid-run.
    tick(); wb(2'b01, 5'd10, 32'h1234, 0); issue(2'b01, 5'd10);
    tick(); idle(); setp(0, 0, 5'd10); #1;
    chk("G10 written", 64'(rd_data[31:0]), 64'h1234);
    chk("G10 busy_cnt", 64'(busy_cnt), 64'd1);
    rstn = 0; #1;
    chk("async G10", 64'(rd_data[31:0]), 64'h0);
    chk("async busy_cnt", 64'(busy_cnt), 64'd0);
    chk("async rd_busy", 64'(rd_busy[0]), 64'd0);
    tick(); rstn = 1;
    tick(); issue(2'b01, 5'd10); #1;
    chk("fresh G10 ready", 64'(iss_ready), 64'd1);

    // Bank separation on parallel ports.
    tick(); idle(); wb(2'b01, 5'd6, 32'h11, 1);
    tick(); wb(2'b10, 5'd6, 32'h22, 0);
    tick(); idle(); setp(0, 0, 5'd6); setp(1, 1, 5'd6); #1;
    chk("G6 port0", 64'(rd_data[31:0]), 64'h11);
    chk("F6 port1", 64'(rd_data[63:32]), 64'h22);
    chk("G10 busy left", 64'(busy_cnt), 64'd1);

    // No-op encodings neither write nor reserve.
    tick(); issue(2'b11, 5'd6); wb(2'b11, 5'd6, 32'h99, 1); #1;
    chk("rw11 ready", 64'(iss_ready), 64'd1);
    chk("rw11 no bypass", 64'(rd_data[31:0]), 64'h11);
    tick(); idle(); #1;
    chk("rw11 no write", 64'(rd_data[63:32]), 64'h22);
    chk("rw11 no reserve", 64'(busy_cnt), 64'd1);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
